// File: rtl/sdrc_bs_pkg.sv
// Shared mode encodings, FSM state type and ratio/shift helpers for the SDRAM bus-width converter.
// No logic of its own; the latency and backpressure notes live in the modules that use it.
// A mode value of 2'b11 is folded onto the 32-bit mode by norm_mode.
package sdrc_bs_pkg;

    localparam logic [1:0] MODE_32 = 2'b00;
    localparam logic [1:0] MODE_16 = 2'b01;
    localparam logic [1:0] MODE_8  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } bs_state_t;

    function automatic logic [1:0] norm_mode(input logic [1:0] w);
        return (w == 2'b11) ? MODE_32 : w;
    endfunction

    function automatic logic [2:0] ratio_of(input logic [1:0] m);
        case (m)
            MODE_16: return 3'd2;
            MODE_8:  return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [1:0] shift_of(input logic [1:0] m);
        case (m)
            MODE_16: return 2'd1;
            MODE_8:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sdrc_bs_rd_assemble.sv
// Packs narrow read beats into a 32-bit application word; the final beat is merged combinationally.
// Latency: zero on the final beat, earlier beats are registered one per strobe.
// Backpressure: none, every strobe is accepted.
module sdrc_bs_rd_assemble (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  beat,
    input  logic [2:0]  ratio,
    input  logic        strobe,
    input  logic [31:0] data,
    output logic [31:0] word
);
    import sdrc_bs_pkg::*;

    logic [23:0] pack;

    always_ff @(posedge clk) begin
        if (reset) begin
            pack <= '0;
        end else if (strobe && ({1'b0, beat} < (ratio - 3'd1))) begin
            if (ratio == 3'd2) begin
                pack[15:0] <= data[15:0];
            end else begin
                case (beat)
                    2'd0:    pack[7:0]   <= data[7:0];
                    2'd1:    pack[15:8]  <= data[7:0];
                    default: pack[23:16] <= data[7:0];
                endcase
            end
        end
    end

    always_comb begin
        word = data;
        case (ratio)
            3'd2:    word = {data[15:0], pack[15:0]};
            3'd4:    word = {data[7:0], pack[23:0]};
            default: word = data;
        endcase
    end

endmodule

// File: rtl/sdrc_bs_convert_mw.sv
// Maps 32-bit application words onto a 32/16/8-bit SDRAM bus; optional sticky protocol check under SDRC_BS_ERR_EN.
// Latency: zero; app_wr_next / app_rd_valid are combinational from the final-beat core strobe.
// Backpressure: core strobes pace the beats; new requests are held off until the current transfer ends.
module sdrc_bs_convert_mw
    import sdrc_bs_pkg::*;
#(
    parameter int APP_AW = 30,
    parameter int APP_DW = 32,
    parameter int APP_BW = 4,
    parameter int APP_RW = 9,
    parameter int SDR_DW = 32,
    parameter int SDR_BW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        sdr_width,
    input  logic              app_req,
    input  logic              app_req_wr_n,
    input  logic              app_req_dma_last,
    input  logic [APP_AW-1:0] app_req_addr,
    input  logic [APP_RW-1:0] app_req_len,
    output logic              app_req_ack,
    output logic              app_req_int,
    output logic              app_req_dma_last_int,
    output logic [APP_AW+1:0] app_req_addr_int,
    output logic [APP_RW+1:0] app_req_len_int,
    input  logic              app_req_ack_int,
    input  logic [APP_DW-1:0] app_wr_data,
    input  logic [APP_BW-1:0] app_wr_en_n,
    output logic [SDR_DW-1:0] app_wr_data_int,
    output logic [SDR_BW-1:0] app_wr_en_n_int,
    input  logic              app_wr_next_int,
    output logic              app_wr_next,
    input  logic [SDR_DW-1:0] app_rd_data_int,
    input  logic              app_rd_valid_int,
    output logic [APP_DW-1:0] app_rd_data,
    output logic              app_rd_valid,
    output logic              bs_err
);

    localparam logic [APP_RW-1:0] ONE_W = 1;

    bs_state_t         state, state_nx;
    logic [1:0]        beat, beat_nx;
    logic [APP_RW-1:0] words_left, words_nx;
    logic [1:0]        mode_q, mode_nx;
    logic [1:0]        cur_mode, eff_mode;
    logic [2:0]        cur_ratio, eff_ratio;
    logic              pass, beat_last, wr_last, rd_last;

    assign cur_mode  = norm_mode(sdr_width);
    assign cur_ratio = ratio_of(cur_mode);
    // Once a transfer is accepted the latched mode owns the datapath, whatever sdr_width does.
    assign eff_mode  = (state == ST_IDLE) ? cur_mode : mode_q;
    assign eff_ratio = ratio_of(eff_mode);
    assign pass      = (eff_ratio == 3'd1);
    assign beat_last = ({1'b0, beat} == (eff_ratio - 3'd1));

    assign app_req_ack          = app_req_ack_int;
    assign app_req_dma_last_int = app_req_dma_last;
    assign app_req_int          = !reset && app_req && (state == ST_IDLE);
    assign app_req_addr_int     = {2'b00, app_req_addr} << shift_of(cur_mode);
    assign app_req_len_int      = {2'b00, app_req_len} << shift_of(cur_mode);
    assign app_wr_next          = !reset && (pass ? app_wr_next_int : wr_last);
    assign app_rd_valid         = !reset && (pass ? app_rd_valid_int : rd_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            beat       <= 2'd0;
            words_left <= '0;
            mode_q     <= MODE_32;
        end else begin
            state      <= state_nx;
            beat       <= beat_nx;
            words_left <= words_nx;
            mode_q     <= mode_nx;
        end
    end

    always_comb begin
        state_nx = state;
        beat_nx  = beat;
        words_nx = words_left;
        mode_nx  = mode_q;
        wr_last  = 1'b0;
        rd_last  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (app_req_ack_int && (cur_ratio != 3'd1)) begin
                    mode_nx  = cur_mode;
                    words_nx = app_req_len - ONE_W;
                    beat_nx  = 2'd0;
                    state_nx = app_req_wr_n ? ST_RD : ST_WR;
                end
            end
            ST_WR, ST_RD: begin
                if ((state == ST_WR) ? app_wr_next_int : app_rd_valid_int) begin
                    if (beat_last) begin
                        wr_last  = (state == ST_WR);
                        rd_last  = (state == ST_RD);
                        beat_nx  = 2'd0;
                        if (words_left == '0) begin
                            state_nx = ST_IDLE;
                        end else begin
                            words_nx = words_left - ONE_W;
                        end
                    end else begin
                        beat_nx = beat + 2'd1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Narrow modes drive the selected slice on the low lanes; unused lanes read as zero data / disabled bytes.
    always_comb begin
        app_wr_data_int = '0;
        app_wr_en_n_int = '1;
        case (eff_mode)
            MODE_16: begin
                app_wr_data_int[15:0] = app_wr_data[{beat[0], 4'b0000} +: 16];
                app_wr_en_n_int[1:0]  = app_wr_en_n[{beat[0], 1'b0} +: 2];
            end
            MODE_8: begin
                app_wr_data_int[7:0] = app_wr_data[{beat, 3'b000} +: 8];
                app_wr_en_n_int[0]   = app_wr_en_n[beat];
            end
            default: begin
                app_wr_data_int = app_wr_data;
                app_wr_en_n_int = app_wr_en_n;
            end
        endcase
    end

    sdrc_bs_rd_assemble u_rd_assemble (
        .clk    (clk),
        .reset  (reset),
        .beat   (beat),
        .ratio  (eff_ratio),
        .strobe (app_rd_valid_int && (state == ST_RD)),
        .data   (app_rd_data_int),
        .word   (app_rd_data)
    );

`ifdef SDRC_BS_ERR_EN
    logic err_q, err_set;

    assign err_set = (!pass && app_rd_valid_int && (state != ST_RD))
                  || (!pass && app_wr_next_int && (state != ST_WR))
                  || (app_req_ack_int && (app_req_len == '0))
                  || (app_req_ack_int && (sdr_width == 2'b11));

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign bs_err = err_q;
`else
    assign bs_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdrc_bs_convert_mw.sv
// Bench for sdrc_bs_convert_mw: vector table, directed multi-cycle sequences and randomized transfers
// checked against a word/beat arithmetic model.
module tb_sdrc_bs_convert_mw;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sdr_width;
    logic        app_req, app_req_wr_n, app_req_dma_last;
    logic [29:0] app_req_addr;
    logic [8:0]  app_req_len;
    logic        app_req_ack, app_req_int, app_req_dma_last_int;
    logic [31:0] app_req_addr_int;
    logic [10:0] app_req_len_int;
    logic        app_req_ack_int;
    logic [31:0] app_wr_data;
    logic [3:0]  app_wr_en_n;
    logic [31:0] app_wr_data_int;
    logic [3:0]  app_wr_en_n_int;
    logic        app_wr_next_int, app_wr_next;
    logic [31:0] app_rd_data_int;
    logic        app_rd_valid_int;
    logic [31:0] app_rd_data;
    logic        app_rd_valid;
    logic        bs_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sdrc_bs_convert_mw dut (
        .clk                  (clk),
        .reset                (reset),
        .sdr_width            (sdr_width),
        .app_req              (app_req),
        .app_req_wr_n         (app_req_wr_n),
        .app_req_dma_last     (app_req_dma_last),
        .app_req_addr         (app_req_addr),
        .app_req_len          (app_req_len),
        .app_req_ack          (app_req_ack),
        .app_req_int          (app_req_int),
        .app_req_dma_last_int (app_req_dma_last_int),
        .app_req_addr_int     (app_req_addr_int),
        .app_req_len_int      (app_req_len_int),
        .app_req_ack_int      (app_req_ack_int),
        .app_wr_data          (app_wr_data),
        .app_wr_en_n          (app_wr_en_n),
        .app_wr_data_int      (app_wr_data_int),
        .app_wr_en_n_int      (app_wr_en_n_int),
        .app_wr_next_int      (app_wr_next_int),
        .app_wr_next          (app_wr_next),
        .app_rd_data_int      (app_rd_data_int),
        .app_rd_valid_int     (app_rd_valid_int),
        .app_rd_data          (app_rd_data),
        .app_rd_valid         (app_rd_valid),
        .bs_err               (bs_err)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [29:0] addr;
        logic [8:0]  len;
        logic [31:0] wdat;
        logic [3:0]  wen;
        logic [31:0] e_addr;
        logic [10:0] e_len;
        logic [31:0] e_wdat;
        logic [3:0]  e_wen;
    } vec_t;

    vec_t        tbl[5];
    logic [31:0] seq_w[2];
    logic [31:0] seq_b[4];
    logic        seq_n[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_strobes();
        app_req_ack_int  = 1'b0;
        app_wr_next_int  = 1'b0;
        app_rd_valid_int = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_strobes();
        tick();
        reset = 1'b0;
    endtask

    // Issues one accepted request and walks all beats; expectations come from word/lane arithmetic.
    task automatic run_txn(input logic [1:0] mode, input logic wr_n, input int len,
                           input logic [29:0] addr, input logic toggle);
        int r, w, bw;
        logic [31:0] mask, exp_d, words[3];
        logic [3:0]  emask, exp_e, ens[3];
        r     = (mode == 2'b01) ? 2 : (mode == 2'b10) ? 4 : 1;
        w     = 32 / r;
        bw    = 4 / r;
        mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        emask = 4'((32'd1 << bw) - 32'd1);
        for (int i = 0; i < 3; i++) begin
            words[i] = $urandom;
            ens[i]   = 4'($urandom);
        end
        sdr_width        = mode;
        app_req          = 1'b1;
        app_req_wr_n     = wr_n;
        app_req_dma_last = 1'($urandom_range(0, 1));
        app_req_addr     = addr;
        app_req_len      = 9'(len);
        app_req_ack_int  = 1'b1;
        #2;
        chk("rnd_req_int", app_req_int, 1);
        chk("rnd_ack", app_req_ack, 1);
        chk("rnd_dma_last", app_req_dma_last_int, app_req_dma_last);
        chk("rnd_addr_int", app_req_addr_int, 64'(addr) * r);
        chk("rnd_len_int", app_req_len_int, 64'(len) * r);
        tick();
        app_req_ack_int = 1'b0;
        if (toggle && r > 1) sdr_width = 2'($urandom_range(0, 3));
        for (int i = 0; i < len; i++) begin
            for (int k = 0; k < r; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    idle_strobes();
                    #2;
                    chk("rnd_gap_wnext", app_wr_next, 0);
                    chk("rnd_gap_rvalid", app_rd_valid, 0);
                    tick();
                end
                if (!wr_n) begin
                    app_wr_data     = words[i];
                    app_wr_en_n     = ens[i];
                    app_wr_next_int = 1'b1;
                    exp_d = (words[i] >> (k * w)) & mask;
                    exp_e = ~emask | (4'(ens[i] >> (k * bw)) & emask);
                    #2;
                    chk("rnd_wr_dat", app_wr_data_int, exp_d);
                    chk("rnd_wr_en", app_wr_en_n_int, exp_e);
                    chk("rnd_wr_next", app_wr_next, (k == r - 1));
                end else begin
                    app_rd_data_int  = ($urandom & ~mask) | ((words[i] >> (k * w)) & mask);
                    app_rd_valid_int = 1'b1;
                    #2;
                    chk("rnd_rd_valid", app_rd_valid, (k == r - 1));
                    if (k == r - 1) chk("rnd_rd_data", app_rd_data, words[i]);
                end
                chk("rnd_req_gate", app_req_int, (r == 1));
                tick();
                idle_strobes();
            end
        end
    endtask

    initial begin
        reset            = 1'b1;
        sdr_width        = 2'b00;
        app_req          = 1'b1;
        app_req_wr_n     = 1'b0;
        app_req_dma_last = 1'b0;
        app_req_addr     = '0;
        app_req_len      = 9'd1;
        app_req_ack_int  = 1'b0;
        app_wr_data      = '0;
        app_wr_en_n      = '1;
        app_wr_next_int  = 1'b1;
        app_rd_data_int  = '0;
        app_rd_valid_int = 1'b1;

        // Reset: registered-looking outputs forced low even with strobes and a request present.
        tick();
        tick();
        #2;
        chk("rst_req_int", app_req_int, 0);
        chk("rst_wr_next", app_wr_next, 0);
        chk("rst_rd_valid", app_rd_valid, 0);
        chk("rst_bs_err", bs_err, 0);
        do_reset();

        tbl[0] = '{2'b00, 30'h10,       9'd3,   32'hAABBCCDD, 4'b0101, 32'h10,       11'd3,     32'hAABBCCDD, 4'b0101};
        tbl[1] = '{2'b01, 30'h10,       9'd2,   32'hAABBCCDD, 4'b0110, 32'h20,       11'd4,     32'h0000CCDD, 4'b1110};
        tbl[2] = '{2'b10, 30'h3FFFFFFF, 9'h1FF, 32'h12345678, 4'b1010, 32'hFFFFFFFC, 11'h7FC,   32'h00000078, 4'b1110};
        tbl[3] = '{2'b11, 30'h2AAAAAAA, 9'd5,   32'hDEADBEEF, 4'b0000, 32'h2AAAAAAA, 11'd5,     32'hDEADBEEF, 4'b0000};
        tbl[4] = '{2'b01, 30'h3FFFFFFF, 9'h100, 32'hFFFF0001, 4'b1111, 32'h7FFFFFFE, 11'h200,   32'h00000001, 4'b1111};
        for (int v = 0; v < 5; v++) begin
            sdr_width        = tbl[v].mode;
            app_req          = 1'b1;
            app_req_dma_last = v[0];
            app_req_addr     = tbl[v].addr;
            app_req_len      = tbl[v].len;
            app_wr_data      = tbl[v].wdat;
            app_wr_en_n      = tbl[v].wen;
            #2;
            chk("tbl_addr_int", app_req_addr_int, tbl[v].e_addr);
            chk("tbl_len_int", app_req_len_int, tbl[v].e_len);
            chk("tbl_wr_dat", app_wr_data_int, tbl[v].e_wdat);
            chk("tbl_wr_en", app_wr_en_n_int, tbl[v].e_wen);
            chk("tbl_req_int", app_req_int, 1);
            chk("tbl_dma_last", app_req_dma_last_int, v[0]);
            tick();
        end

        // Mode 16, write two words from address 0x10.
        seq_w = '{32'hAABBCCDD, 32'h11223344};
        seq_b = '{32'h0000CCDD, 32'h0000AABB, 32'h00003344, 32'h00001122};
        seq_n = '{1'b0, 1'b1, 1'b0, 1'b1};
        sdr_width       = 2'b01;
        app_req_wr_n    = 1'b0;
        app_req_addr    = 30'h10;
        app_req_len     = 9'd2;
        app_req_ack_int = 1'b1;
        #2;
        chk("w16_addr", app_req_addr_int, 32'h20);
        chk("w16_len", app_req_len_int, 11'd4);
        tick();
        app_req_ack_int = 1'b0;
        for (int j = 0; j < 4; j++) begin
            app_wr_data     = seq_w[j / 2];
            app_wr_en_n     = 4'b0000;
            app_wr_next_int = 1'b1;
            #2;
            chk("w16_beat", app_wr_data_int, seq_b[j]);
            chk("w16_en", app_wr_en_n_int, 4'b1100);
            chk("w16_next", app_wr_next, seq_n[j]);
            chk("w16_gate", app_req_int, 0);
            tick();
        end
        app_wr_next_int = 1'b0;
        #2;
        chk("w16_idle_req", app_req_int, 1);
        tick();

        // Mode 8, read one word from beats 44,33,22,11.
        sdr_width       = 2'b10;
        app_req_wr_n    = 1'b1;
        app_req_len     = 9'd1;
        app_req_ack_int = 1'b1;
        tick();
        app_req_ack_int = 1'b0;
        seq_b = '{32'hFFFFFF44, 32'hABCDEF33, 32'h00000022, 32'h12345611};
        for (int j = 0; j < 4; j++) begin
            app_rd_data_int  = seq_b[j];
            app_rd_valid_int = 1'b1;
            #2;
            chk("r8_valid", app_rd_valid, (j == 3));
            if (j == 3) chk("r8_data", app_rd_data, 32'h11223344);
            tick();
        end
        app_rd_valid_int = 1'b0;
        #2;
        chk("r8_idle_req", app_req_int, 1);
        tick();

        // Mode 16 read with sdr_width flipped to 8-bit mid-transfer; ratio 2 must stay in force.
        sdr_width       = 2'b01;
        app_req_ack_int = 1'b1;
        tick();
        app_req_ack_int  = 1'b0;
        sdr_width        = 2'b10;
        app_rd_data_int  = 32'hDEAD5566;
        app_rd_valid_int = 1'b1;
        #2;
        chk("tgl_valid0", app_rd_valid, 0);
        chk("tgl_gate", app_req_int, 0);
        tick();
        app_rd_data_int = 32'hBEEF7788;
        #2;
        chk("tgl_valid1", app_rd_valid, 1);
        chk("tgl_data", app_rd_data, 32'h77885566);
        tick();
        app_rd_valid_int = 1'b0;
        #2;
        chk("tgl_idle_req", app_req_int, 1);
        tick();

        // Reset in the middle of a mode-8 read, then a clean read.
        sdr_width       = 2'b10;
        app_req_ack_int = 1'b1;
        tick();
        app_req_ack_int  = 1'b0;
        app_rd_data_int  = 32'h00000099;
        app_rd_valid_int = 1'b1;
        tick();
        do_reset();
        app_rd_data_int  = 32'h000000EE;
        app_rd_valid_int = 1'b1;
        #2;
        chk("abort_idle_req", app_req_int, 1);
        chk("abort_no_valid", app_rd_valid, 0);
        tick();
        app_rd_valid_int = 1'b0;
        app_req_ack_int  = 1'b1;
        tick();
        app_req_ack_int = 1'b0;
        seq_b = '{32'h000000A1, 32'h000000B2, 32'h000000C3, 32'h000000D4};
        for (int j = 0; j < 4; j++) begin
            app_rd_data_int  = seq_b[j];
            app_rd_valid_int = 1'b1;
            #2;
            if (j == 3) begin
                chk("abort_next_valid", app_rd_valid, 1);
                chk("abort_next_data", app_rd_data, 32'hD4C3B2A1);
            end
            tick();
        end
        app_rd_valid_int = 1'b0;
        tick();

        for (int t = 0; t < 40; t++) begin
            run_txn(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(1, 3),
                    30'($urandom), 1'($urandom_range(0, 1)));
        end

        // Stray read strobe in IDLE while in 16-bit mode.
        do_reset();
        app_req          = 1'b0;
        sdr_width        = 2'b01;
        app_rd_valid_int = 1'b1;
        tick();
        app_rd_valid_int = 1'b0;
        #2;
`ifdef SDRC_BS_ERR_EN
        chk("err_set", bs_err, 1);
        repeat (3) tick();
        chk("err_hold", bs_err, 1);
        do_reset();
        #2;
        chk("err_clear", bs_err, 0);
`else
        chk("err_tied0", bs_err, 0);
        repeat (3) tick();
        chk("err_tied0_hold", bs_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
